core_dmem_ctrl: RTL

- Data-memory responder: the slave end of the core's MEM_ADDR / MEM_DATA / MEM_WE / MEM_IN data port.
- Owns a word-organised single-port RAM (no byte enables).
- Performs read-modify-write for SB/SH stores, using the core's lane-replicated store data.
- Returns sign/zero-extended, lane-aligned load data for LB/LH/LW/LBU/LHU.
- Adds a REQ/ACK handshake so the multicycle core can stall in its MEMORY state until the access completes.

---
 rtl/core_dmem_ctrl_if.sv | 24 ++
 rtl/core_dmem_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/core_dmem_ctrl_if.sv
// Core data-port bundle: request side driven by the core,
// response side driven by the data-memory controller.
interface core_dmem_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] data;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output req, we, addr, data, size, load_unsigned,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, we, addr, data, size, load_unsigned,
      output rdata, ack, busy, err
   );
endinterface

// File: rtl/core_dmem_ctrl.sv
// Data-memory responder: word RAM with read-modify-write for
// sub-word stores and extended, lane-aligned load data.
module core_dmem_ctrl #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic            CLK,
   input  logic            RST_N,
   core_dmem_ctrl_if.slave mem
);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [1:0]            lane_q;
   logic [1:0]            size_q;
   logic                  we_q;
   logic                  uns_q;
   logic                  err_q;
   logic [31:0]           data_q;
   logic [31:0]           rdata_q;
   logic [31:0]           ram_q;
   logic [31:0]           ram_wdata;
   logic [31:0]           merged;
   logic [31:0]           load_val;
   logic                  ram_we;
   logic                  ram_re;
   logic                  req_err;
   logic                  capture;
   logic                  ack;
   logic [4:0]            bsh;
   logic [4:0]            hsh;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic                  unused_addr;

   logic [31:0] ram [2**ADDR_WIDTH];

   assign unused_addr = ^mem.addr[31:ADDR_WIDTH+2];
   assign capture     = (state_q == IDLE) && mem.req;

   always_comb begin
      req_err = 1'b0;
      unique case (mem.size)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = mem.addr[0];
         2'b10:   req_err = |mem.addr[1:0];
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_idx   = idx_q;
      ram_wdata = merged;
      unique case (state_q)
         IDLE: begin
            if (mem.req) begin
               ram_idx   = mem.addr[ADDR_WIDTH+1:2];
               ram_wdata = mem.data;
               if (req_err) begin
                  state_d = DONE;
               end else if (mem.we && mem.size == 2'b10) begin
                  ram_we  = 1'b1;
                  state_d = DONE;
               end else begin
                  ram_re  = 1'b1;
                  state_d = READ;
               end
            end
         end
         READ: begin
            ram_we  = we_q;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane merge for sub-word stores and extraction for loads
   always_comb begin
      bsh    = {lane_q, 3'b000};
      hsh    = {lane_q[1], 4'b0000};
      byte_v = ram_q[bsh +: 8];
      half_v = ram_q[hsh +: 16];
      merged = ram_q;
      if (size_q == 2'b00) begin
         merged[bsh +: 8] = data_q[bsh +: 8];
      end else begin
         merged[hsh +: 16] = data_q[hsh +: 16];
      end
      load_val = ram_q;
      unique case (size_q)
         2'b00:   load_val = {{24{byte_v[7] & ~uns_q}}, byte_v};
         2'b01:   load_val = {{16{half_v[15] & ~uns_q}}, half_v};
         default: load_val = ram_q;
      endcase
   end

   // Reset blocks any RAM access, including a pending RMW write
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         if (ram_we) begin
            ram[ram_idx] <= ram_wdata;
         end else if (ram_re) begin
            ram_q <= ram[ram_idx];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (capture) begin
         idx_q  <= mem.addr[ADDR_WIDTH+1:2];
         lane_q <= mem.addr[1:0];
         we_q   <= mem.we;
         data_q <= mem.data;
         size_q <= mem.size;
         uns_q  <= mem.load_unsigned;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            err_q <= req_err;
            if (req_err) begin
               rdata_q <= '0;
            end
         end else if (state_q == READ && !we_q) begin
            rdata_q <= load_val;
         end
      end
   end

   assign ack       = (state_q == DONE);
   assign mem.ack   = ack;
   assign mem.busy  = (state_q != IDLE);
   assign mem.err   = ack & err_q;
   assign mem.rdata = rdata_q;

endmodule
